// File: rtl/pulse_latch_pkg.sv
// pulse_latch_pkg
// Shared constants for the pulse_latch block and its per-channel capture cell.
package pulse_latch_pkg;

    // Default synchronizer depth; two flops is the minimum for metastability settling.
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage : pulse_latch_pkg

// File: rtl/pulse_capture_cell.sv
// pulse_capture_cell
// One channel of pulse_latch: captures a rising edge on an asynchronous input,
// moves it into the clk_i domain and raises a sticky flag that holds until reset.
//
// Ports:
//   clk_i  - system clock; the flag changes only on its rising edge
//   rst_i  - synchronous active-low reset, sampled on rising clk_i
//   sig_i  - asynchronous event input; its rising edge is the event
//   sig_o  - sticky event flag, registered in the clk_i domain
module pulse_capture_cell
    import pulse_latch_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic sig_o
);

    logic                   toggle_q;
    logic                   toggle_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out_s;
    logic                   ref_q;
    logic                   event_s;
    logic                   flag_q;
    logic                   flag_d;

    // The event is encoded as a level change, so a pulse of any width survives
    // until the clk_i domain has seen it. No reset: its start value is irrelevant
    // because the reference register is aligned to it during reset.
    assign toggle_d = ~toggle_q;

    // Toggle flop clocked directly by the asynchronous event.
    always_ff @(posedge sig_i) begin
        toggle_q <= toggle_d;
    end

    // Synchronizer chain; deliberately not reset so it keeps tracking the toggle
    // through reset and the reference can be realigned to its output.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_q};
    end

    assign sync_out_s = sync_q[SYNC_STAGES-1];
    assign event_s    = sync_out_s ^ ref_q;

    // Next value of the sticky flag outside reset.
    always_comb begin
        flag_d = flag_q | event_s;
    end

    // Reference follows the synchronizer every cycle, including during reset,
    // which both discards edges arriving in reset and absorbs a leftover toggle.
    always_ff @(posedge clk_i) begin
        ref_q <= sync_out_s;
        if (!rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign sig_o = flag_q;

endmodule : pulse_capture_cell

// File: rtl/pulse_latch.sv
// pulse_latch
// Vector of WIDTH independent asynchronous pulse catchers. Each channel turns a
// rising edge on sig_i[n] (possibly narrower than a clk_i period) into a sticky,
// clk_i-synchronous flag on sig_o[n] that holds until reset.
//
// Ports:
//   clk_i  - system clock; all outputs change only on its rising edge
//   rst_i  - synchronous active-low reset, sampled on rising clk_i
//   sig_i  - WIDTH asynchronous event inputs, rising edge is the event
//   sig_o  - WIDTH sticky event flags, registered in the clk_i domain
module pulse_latch
    import pulse_latch_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] sig_o
);

    // One fully independent capture cell per channel.
    for (genvar n = 0; n < WIDTH; n++) begin : gen_ch
        pulse_capture_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .sig_i (sig_i[n]),
            .sig_o (sig_o[n])
        );
    end

endmodule : pulse_latch

// File: tb/tb_pulse_latch.sv
// tb_pulse_latch
// Directed bench for pulse_latch: a WIDTH=1 instance for the single-channel
// scenarios and a WIDTH=4 instance for channel independence. Inputs change on
// the falling clock edge, outputs are sampled on the falling edge.
module tb_pulse_latch;

    logic       clk_s  = 1'b0;
    logic       rst_s  = 1'b0;
    logic [0:0] sig1_s = 1'b0;
    logic [0:0] out1_s;
    logic [3:0] sig4_s = 4'b0000;
    logic [3:0] out4_s;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_latch #(
        .WIDTH       (1),
        .SYNC_STAGES (2)
    ) dut1 (
        .clk_i (clk_s),
        .rst_i (rst_s),
        .sig_i (sig1_s),
        .sig_o (out1_s)
    );

    pulse_latch #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut4 (
        .clk_i (clk_s),
        .rst_i (rst_s),
        .sig_i (sig4_s),
        .sig_o (out4_s)
    );

    // 20 ns clock, first rising edge at 10 ns.
    initial begin
        forever #10 clk_s = ~clk_s;
    end

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_s);
    endtask

    task automatic pulse1();
        sig1_s = 1'b1;
        #5;
        sig1_s = 1'b0;
    endtask

    task automatic pulse4(input int ch);
        sig4_s[ch] = 1'b1;
        #5;
        sig4_s[ch] = 1'b0;
    endtask

    // Pulse issued 10 ns before a rising edge: sync0 at edge 1, sync1 at edge 2,
    // flag at edge 3. Sampled 10 ns after edges 2 and 3.
    task automatic latency1(input string tag);
        pulse1();
        tick(2);
        check_eq({tag, "_early"}, {3'b000, out1_s}, 4'b0000);
        tick(1);
        check_eq({tag, "_set"}, {3'b000, out1_s}, 4'b0001);
    endtask

    initial begin
        // Reset, idle: three rising edges in reset.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("rst_idle", {3'b000, out1_s}, 4'b0000);
        end
        rst_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq("no_spurious", {3'b000, out1_s}, 4'b0000);
        end

        // Single narrow pulse, then the flag holds for 100 ns.
        latency1("narrow");
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("hold", {3'b000, out1_s}, 4'b0001);
        end

        // One-cycle reset clears the flag; a later pulse sets it again.
        rst_s = 1'b0;
        tick(1);
        check_eq("rst_clear", {3'b000, out1_s}, 4'b0000);
        rst_s = 1'b1;
        tick(2);
        latency1("after_clear");

        // Reset mid-flight: pulse, then three reset cycles starting 20 ns later.
        pulse1();
        tick(1);
        rst_s = 1'b0;
        tick(3);
        check_eq("midflight_rst", {3'b000, out1_s}, 4'b0000);
        rst_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq("midflight_after", {3'b000, out1_s}, 4'b0000);
        end
        latency1("midflight_later");

        // Pulse during a four-cycle reset.
        rst_s = 1'b0;
        tick(1);
        check_eq("pdr_clear", {3'b000, out1_s}, 4'b0000);
        pulse1();
        tick(3);
        rst_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq("pdr_after", {3'b000, out1_s}, 4'b0000);
        end
        check_eq("w4_idle", out4_s, 4'b0000);

        // Multi-channel independence.
        pulse4(2);
        tick(2);
        check_eq("w4_ch2_early", out4_s, 4'b0000);
        tick(1);
        check_eq("w4_ch2_set", out4_s, 4'b0100);
        tick(2);
        pulse4(0);
        tick(2);
        check_eq("w4_ch0_early", out4_s, 4'b0100);
        tick(1);
        check_eq("w4_ch0_set", out4_s, 4'b0101);
        check_eq("w1_untouched", {3'b000, out1_s}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_latch
